// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and default operand width for the
//               sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Multiplier control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width
  localparam int MULT_N = 4;

endpackage
`default_nettype wire

// File: rtl/csa_n.sv
`default_nettype none
// ============================================================================
// Module      : csa_n
// Description : N-bit carry-select adder. The lower half ripples normally;
//               the upper half is computed for both carry-in values and the
//               lower-half carry picks the result.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int c_lo = N / 2;
  localparam int c_hi = N - c_lo;

  logic [c_lo:0] w_lo;
  logic [c_hi:0] w_hi0;
  logic [c_hi:0] w_hi1;

  // Lower half including the external carry-in
  assign w_lo  = {1'b0, a[c_lo-1:0]} + {1'b0, b[c_lo-1:0]} + {{c_lo{1'b0}}, ci};

  // Upper half speculatively computed for carry-in 0 and 1
  assign w_hi0 = {1'b0, a[N-1:c_lo]} + {1'b0, b[N-1:c_lo]};
  assign w_hi1 = {1'b0, a[N-1:c_lo]} + {1'b0, b[N-1:c_lo]} + {{c_hi{1'b0}}, 1'b1};

  // Carry out of the lower half selects the upper result
  assign {co, s} = w_lo[c_lo] ? {w_hi1, w_lo[c_lo-1:0]}
                              : {w_hi0, w_lo[c_lo-1:0]};

endmodule
`default_nettype wire

// File: rtl/seq_mult_csa.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_csa
// Description : N-bit unsigned shift-and-add multiplier with valid/ready
//               handshakes. One accumulate per cycle through a carry-select
//               adder; 2N-bit product after exactly N iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_csa
  import mult_pkg::*;
#(
  parameter int N  = MULT_N,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  state_t          r_state;
  logic [N-1:0]    r_acc_hi;
  logic [N-1:0]    r_mcand;
  logic [N-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [2*N-1:0]  r_p;

  logic [N-1:0]    w_addend;
  logic [N-1:0]    w_sum;
  logic            w_co;
  logic [2*N-1:0]  w_next;

  // Multiplicand is added only when the current multiplier LSB is set
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  csa_n #(
    .N (N)
  ) u_csa (
    .a  (r_acc_hi),
    .b  (w_addend),
    .ci (1'b0),
    .s  (w_sum),
    .co (w_co)
  );

  // Carry-out lands in the top product bit; the consumed multiplier LSB drops off
  assign w_next = {w_co, w_sum, r_mplier[N-1:1]};

  // Control FSM and datapath shift registers with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc_hi    <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_p         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand    <= a;
            r_mplier   <= b;
            r_acc_hi   <= '0;
            r_cnt      <= CW'(N - 1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          {r_acc_hi, r_mplier} <= w_next;
          if (r_cnt == '0) begin
            r_p         <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // Product stays on p after the transfer
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_csa.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_csa
// Description : Self-checking bench for seq_mult_csa (N=4) with a queue of
//               expected products filled at drive time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_csa;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  seq_mult_csa #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter, read only on falling edges
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // Drive one operand pair, wait for the product, optionally stall, then take it
  task automatic op(input logic [3:0] x, input logic [3:0] y, input int stall,
                    output logic [7:0] got, output int lat, output bit to);
    int n;
    int t0;
    to = 0;
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) to = 1;
    exp_q.push_back(8'(x) * 8'(y));
    @(negedge clk);
    t0 = cyc;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) to = 1;
    lat = cyc - t0;
    repeat (stall) @(negedge clk);
    got = p;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b p=%h need 1 0 0 00",
               in_ready, out_valid, busy, p);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int t0;
    int n;
    logic [7:0] e;
    a = 4'd13; b = 4'd11; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(8'd13 * 8'd11);
    @(negedge clk);
    t0 = cyc;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept got rdy=%b busy=%b need rdy=0 busy=1", in_ready, busy);
    end
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid || (cyc - t0) != 4) begin
      errors++;
      $display("FAIL basic_latency got %0d cycles vld=%b need 4", cyc - t0, out_valid);
    end
    e = pop_exp();
    checks++;
    if (p !== e) begin
      errors++;
      $display("FAIL basic_product got %0d need %0d", p, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010 || p !== 8'd143) begin
      errors++;
      $display("FAIL basic_release got vld=%b rdy=%b busy=%b p=%0d need 0 1 0 143",
               out_valid, in_ready, busy, p);
    end
  endtask

  task automatic test_max_zero();
    logic [3:0] xs[3] = '{4'd15, 4'd0, 4'd9};
    logic [3:0] ys[3] = '{4'd15, 4'd9, 4'd0};
    logic [7:0] got;
    logic [7:0] e;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      op(xs[i], ys[i], 0, got, lat, to);
      e = pop_exp();
      checks++;
      if (to || got !== e || lat != 4) begin
        errors++;
        $display("FAIL max_zero[%0d] got p=%0d lat=%0d to=%0d need p=%0d lat=4",
                 i, got, lat, to, e);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] e;
    a = 4'd6; b = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(8'd6 * 8'd7);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    e = pop_exp();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== e) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got vld=%b rdy=%b p=%0d need 1 0 %0d",
                 i, out_valid, in_ready, p, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got vld=%b rdy=%b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] xs[3] = '{4'd5, 4'd12, 4'd7};
    logic [3:0] ys[3] = '{4'd3, 4'd10, 4'd9};
    int acc_cyc[3] = '{0, 0, 0};
    int idx = 0;
    int nout = 0;
    bit just_acc = 0;
    logic [7:0] e;
    a = xs[0]; b = ys[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 80 && nout < 3; c++) begin
      if (out_valid) begin
        e = pop_exp();
        checks++;
        if (p !== e) begin
          errors++;
          $display("FAIL b2b_product[%0d] got %0d need %0d", nout, p, e);
        end
        nout++;
      end
      if (in_valid && in_ready && idx < 3) begin
        exp_q.push_back(8'(xs[idx]) * 8'(ys[idx]));
        acc_cyc[idx] = cyc + 1;
        just_acc = 1;
      end
      @(negedge clk);
      if (just_acc) begin
        just_acc = 0;
        idx++;
        if (idx < 3) begin a = xs[idx]; b = ys[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nout != 3 || acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
      errors++;
      $display("FAIL b2b_spacing got outs=%0d gaps=%0d,%0d need 3 outs gaps 6,6",
               nout, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  task automatic test_reset_midop();
    logic [7:0] got;
    logic [7:0] e;
    int lat;
    bit to;
    bit seen;
    a = 4'd10; b = 4'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midop_async_reset got rdy=%b vld=%b busy=%b p=%h need 1 0 0 00",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_no_output got out_valid=1 need 0");
    end
    op(4'd3, 4'd4, 0, got, lat, to);
    e = pop_exp();
    checks++;
    if (to || got !== e || lat != 4) begin
      errors++;
      $display("FAIL midop_recover got p=%0d lat=%0d to=%0d need p=%0d lat=4", got, lat, to, e);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] got;
    logic [7:0] e;
    int lat;
    bit to;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op(4'(x), 4'(y), int'($urandom_range(0, 3)), got, lat, to);
        e = pop_exp();
        checks++;
        if (to || got !== e || lat != 4) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d got p=%0d lat=%0d need p=%0d lat=4",
                   x, y, got, lat, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung handshake
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/seq_mult_csa.md
Name: seq_mult_csa

Overview:
- N-bit unsigned sequential shift-and-add multiplier with valid/ready handshakes on input and output.
- Sits directly downstream of the carry-select adder stage. Each iteration feeds the partial-product accumulator through one csa_n instance and consumes its sum and carry-out.
- Result: 2N-bit product after a fixed N-cycle compute latency. Gives the array-multiplier work a low-area, multi-cycle alternative.

Parameters:
- N, 4, operand width in bits (≥2); product width is 2N.
- CW, $clog2(N), iteration counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b present.
- in_ready  output  1  block can accept operands.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- out_valid  output  1  product p valid.
- out_ready  input  1  consumer accepts p.
- p  output  2N  product a*b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous-release usage):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, p=0.
  - Internal acc_hi, mcand, mplier and cnt all cleared.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready at edge t0: mcand<=a, mplier<=b, acc_hi<=0, cnt<=N-1, go to RUN.
  - Operands are sampled only at this edge.
- RUN: in_ready=0. One iteration per edge.
  - Adder inputs: a=acc_hi, b=(mplier[0] ? mcand : 0), ci=0. Outputs {co,s}.
  - Update: {acc_hi, mplier} <= {co, s, mplier} >> 1. This is an (2N+1)-bit right shift; the LSB of mplier is discarded.
  - When cnt==0 this iteration is the last one: go to DONE. Otherwise cnt<=cnt-1.
- Latency:
  - Exactly N iterations, at edges t1..tN.
  - out_valid=1 in the cycle after edge tN, independent of operand values. A zero operand gets no early exit.
- DONE:
  - out_valid=1, p={acc_hi, mplier}.
  - p is held stable while out_valid && !out_ready.
  - On out_ready at an edge: go to IDLE, out_valid<=0. p keeps its last value; it is don't-care when out_valid=0, but the RTL holds it.
- No input/output bypass:
  - in_ready=0 in DONE even when out_ready=1.
  - Minimum spacing between accepts is N+2 cycles: accept, N iterations, one DONE cycle.
- Width rules: acc_hi is N bits, and the adder carry-out feeds the shift as bit 2N-1. The product never overflows 2N bits.
- in_valid while not in IDLE is ignored. No error flag; the upstream stage must hold in_valid until in_ready.
- out_ready while not in DONE is ignored.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The in-flight product is discarded and no out_valid is produced.
- busy = (state != IDLE).

Decomposition:
- Shared package mult_pkg:
  - state enum IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant MULT_N=4.
- Sub-module: existing csa_n, with ports a, b, ci, s, co, instantiated once as the N-bit accumulate adder.
  - ci is tied to 0.
  - With N≠4, a width-matched csa_n build is required.
- Control FSM and datapath shift registers stay in seq_mult_csa.

Test Plan (N=4):
- Basic: reset, then a=13, b=11 with in_valid one cycle -> in_ready drops next cycle; out_valid rises exactly 4 clocks after the accept edge with p=143. out_ready=1 -> IDLE next cycle.
- Max/carry path: a=15, b=15 -> p=225 (8'hE1); carry-out into bit 7 exercised. Also a=0,b=9 and a=9,b=0 -> p=0 with the same 4-cycle latency.
- Backpressure: a=6, b=7, out_ready=0 for 5 cycles after out_valid -> p=42 stable, in_ready=0 throughout. out_ready=1 -> one transfer, then in_ready=1.
- Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> accepts exactly 6 cycles apart; products in order. Extra in_valid during RUN is not consumed.
- Reset mid-op: assert rst_n=0 asynchronously during iteration 2 of a=10,b=5 -> outputs go to reset values without a clock edge. After release, a new a=3,b=4 yields p=12 at normal latency.
- Exhaustive: all 256 (a,b) pairs with random out_ready stalls -> p==a*b, scored against a golden model.
